// File: rtl/cpu_sched_pkg.sv
// Shared scheduler types: register tag width, station count and the issued payload.
package cpu_sched_pkg;

    localparam int REG_FILE_ADDR_WIDTH = 7;
    localparam int REG_STATIONS_WIDTH  = 2;

    typedef struct packed {
        logic [31:0]                    instr;
        logic [REG_FILE_ADDR_WIDTH-1:0] rd;
        logic [REG_FILE_ADDR_WIDTH-1:0] rs1;
        logic [REG_FILE_ADDR_WIDTH-1:0] rs2;
    } issue_payload_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req at or after ptr, wrapping, via a double-width
// masked priority encode.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [N-1:0]   req_masked;
    logic [2*N-1:0] req_dbl;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_masked[i] = req[i] && (i >= int'(ptr));
        end
        // Masked copy in the low half wins; the unmasked upper half covers the wrap.
        req_dbl = {req, req_masked};
        gnt_idx = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (req_dbl[i]) gnt_idx = IW'(i % N);
        end
        gnt_valid = |req;
    end

endmodule

// File: rtl/rs_issue_select.sv
// Issue stage: picks one ready reservation-station entry per cycle, holds it in an
// output register for the FU handshake and pulses a clear back to the stations.
module rs_issue_select
    import cpu_sched_pkg::*;
#(
    parameter  int REG_FILE_ADDR_WIDTH = cpu_sched_pkg::REG_FILE_ADDR_WIDTH,
    parameter  int REG_STATIONS_WIDTH  = cpu_sched_pkg::REG_STATIONS_WIDTH,
    localparam int N  = 2 ** REG_STATIONS_WIDTH,
    localparam int RW = REG_FILE_ADDR_WIDTH,
    localparam int SW = REG_STATIONS_WIDTH
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic [N-1:0]    station_valid,
    input  logic [N-1:0]    station_rs1_ready,
    input  logic [N-1:0]    station_rs2_ready,
    input  logic [32*N-1:0] station_instr,
    input  logic [RW*N-1:0] station_rd,
    input  logic [RW*N-1:0] station_rs1,
    input  logic [RW*N-1:0] station_rs2,
    output logic            clear_en,
    output logic [SW-1:0]   clear_idx,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [31:0]     issue_instr,
    output logic [RW-1:0]   issue_rd,
    output logic [RW-1:0]   issue_rs1,
    output logic [RW-1:0]   issue_rs2,
    output logic [SW-1:0]   issue_idx,
    output logic [31:0]     issue_count
);

    logic [N-1:0]   eligible;
    logic           sel_valid;
    logic [SW-1:0]  sel_idx;
    logic           load;
    issue_payload_t sel_payload;

    issue_payload_t payload_q;
    logic           valid_q;
    logic [SW-1:0]  idx_q;
    logic [SW-1:0]  rr_ptr_q;
    logic [31:0]    count_q;

    assign eligible = station_valid & station_rs1_ready & station_rs2_ready;

    rr_arbiter #(.N(N)) u_arb (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .gnt_valid (sel_valid),
        .gnt_idx   (sel_idx)
    );

    always_comb begin
        sel_payload.instr = station_instr[32*sel_idx +: 32];
        sel_payload.rd    = station_rd [RW*sel_idx +: RW];
        sel_payload.rs1   = station_rs1[RW*sel_idx +: RW];
        sel_payload.rs2   = station_rs2[RW*sel_idx +: RW];
    end

    // The station frees the entry on the same edge it is latched here.
    assign load      = (!valid_q || issue_ready) && !flush && !reset && sel_valid;
    assign clear_en  = load;
    assign clear_idx = sel_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            payload_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            rr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            if (valid_q && issue_ready && !flush) count_q <= count_q + 32'd1;
            if (flush) begin
                valid_q <= 1'b0;
            end else if (load) begin
                payload_q <= sel_payload;
                idx_q     <= sel_idx;
                valid_q   <= 1'b1;
                rr_ptr_q  <= sel_idx + SW'(1);
            end else if (valid_q && issue_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign issue_valid = valid_q;
    assign issue_instr = payload_q.instr;
    assign issue_rd    = payload_q.rd;
    assign issue_rs1   = payload_q.rs1;
    assign issue_rs2   = payload_q.rs2;
    assign issue_idx   = idx_q;
    assign issue_count = count_q;

endmodule
